// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic cluster: divider FSM states and
// iteration-counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_SIZE_DEFAULT = 4;

  // Counter must hold 0..size-1; never narrower than one bit.
  function automatic int cnt_width(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational ripple-carry adder/subtractor: o_sum = i_a + (i_b ^ ctrl) + ctrl.
// ctrl=1 gives i_a - i_b in two's complement.
module addsub_unit #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ctrl,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_b_x;

  assign w_b_x = i_b ^ {W{i_ctrl}};

  always_comb begin
    logic c;
    // NOTE: combinational logic uses blocking '=' so the carry ripples through
    // the loop within one evaluation; clocked state elsewhere uses '<='.
    c = i_ctrl;
    for (int i = 0; i < W; i++) begin
      o_sum[i] = i_a[i] ^ w_b_x[i] ^ c;
      c        = (i_a[i] & w_b_x[i]) | (c & (i_a[i] ^ w_b_x[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned non-restoring divider: one quotient bit per clock over a
// single shared SIZE+1-bit add/subtract unit, with start/busy/done handshake.
module seq_divider
  import arith_pkg::*;
#(
  parameter int SIZE = DIV_SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int            CW        = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST_ITER = CW'(SIZE - 1);

  div_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic [SIZE:0]   r_p;      // signed partial remainder
  logic [SIZE:0]   r_d;      // latched divisor, zero-extended
  logic [SIZE-1:0] r_a;      // dividend shifting out, quotient shifting in

  logic [SIZE:0]   w_add_a;
  logic [SIZE:0]   w_sum;
  logic            w_ctrl;
  logic            w_unused_cout;

  // RUN feeds the shifted remainder and picks add/subtract from P's sign;
  // FIX (and every other state) presents P + D for the final correction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_add_a = r_p;
    w_ctrl  = 1'b0;
    if (r_state == RUN) begin
      w_add_a = {r_p[SIZE-1:0], r_a[SIZE-1]};
      w_ctrl  = ~r_p[SIZE];
    end
  end

  addsub_unit #(.W(SIZE + 1)) u_addsub (
    .i_a    (w_add_a),
    .i_b    (r_d),
    .i_ctrl (w_ctrl),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand latches are reset along with the outputs so an abort
      // mid-division leaves no stale partial state behind.
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_d         <= '0;
      r_a         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d   <= {1'b0, divisor};
            r_a   <= dividend;
            r_p   <= '0;
            r_cnt <= '0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          r_p   <= w_sum;
          r_a   <= {r_a[SIZE-2:0], ~w_sum[SIZE]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          if (r_p[SIZE]) begin
            r_p       <= w_sum;
            remainder <= w_sum[SIZE-1:0];
          end else begin
            remainder <= r_p[SIZE-1:0];
          end
          quotient    <= r_a;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
